// File: rtl/wb_regfile_if.sv
// MEM/WB -> writeback bundle: the write request and retire information for the instruction in WB.
// The pipeline register drives it (master) and the register file consumes it (slave).
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [1:0]        wb_rf_we;
  logic [DATA_W-1:0] wb_wD;
  logic [ADDR_W-1:0] wb_wR;
  logic [31:0]       wb_pc;
  logic              wb_flag;

  modport master (
    output wb_rf_we,
    output wb_wD,
    output wb_wR,
    output wb_pc,
    output wb_flag
  );

  modport slave (
    input wb_rf_we,
    input wb_wD,
    input wb_wR,
    input wb_pc,
    input wb_flag
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback-stage register file: commits the MEM/WB write and serves two bypassed ID read ports.
// It also emits a registered commit trace and counts retired instructions.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  wb_regfile_if.slave       wb,
  input  logic [ADDR_W-1:0] rR1,
  input  logic [ADDR_W-1:0] rR2,
  output logic [DATA_W-1:0] rD1,
  output logic [DATA_W-1:0] rD2,
  output logic              dbg_wb_have_inst,
  output logic [31:0]       dbg_wb_pc,
  output logic              dbg_wb_ena,
  output logic [ADDR_W-1:0] dbg_wb_reg,
  output logic [DATA_W-1:0] dbg_wb_value,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  logic              have_q, have_d;
  logic              ena_q, ena_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic commit;

  // Bubbles and x0 destinations never reach the array.
  assign commit = wb.wb_flag & (|wb.wb_rf_we) & (wb.wb_wR != '0);

  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[wb.wb_wR] = wb.wb_wD;
    end
  end

  // The bypass ignores rst so a same-cycle commit stays visible during the reset cycle.
  always_comb begin
    rD1 = regs_q[rR1];
    if (rR1 == '0) begin
      rD1 = '0;
    end else if (commit && (rR1 == wb.wb_wR)) begin
      rD1 = wb.wb_wD;
    end
  end

  always_comb begin
    rD2 = regs_q[rR2];
    if (rR2 == '0) begin
      rD2 = '0;
    end else if (commit && (rR2 == wb.wb_wR)) begin
      rD2 = wb.wb_wD;
    end
  end

  always_comb begin
    have_d  = wb.wb_flag;
    ena_d   = commit;
    pc_d    = pc_q;
    reg_d   = reg_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    if (wb.wb_flag) begin
      pc_d    = wb.wb_pc;
      reg_d   = wb.wb_wR;
      value_d = wb.wb_wD;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      have_q  <= 1'b0;
      ena_q   <= 1'b0;
      pc_q    <= '0;
      reg_q   <= '0;
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      have_q  <= have_d;
      ena_q   <= ena_d;
      pc_q    <= pc_d;
      reg_q   <= reg_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_wb_have_inst = have_q;
  assign dbg_wb_ena       = ena_q;
  assign dbg_wb_pc        = pc_q;
  assign dbg_wb_reg       = reg_q;
  assign dbg_wb_value     = value_q;
  assign retire_cnt       = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset/wrap sequences, random traffic.
// A second instance with a 4-bit counter exercises the retire counter wrap.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  rR1, rR2;
  logic [31:0] rD1, rD2, rD1_n, rD2_n;
  logic        have, ena, have_n, ena_n;
  logic [31:0] pc, pc_n, value, value_n;
  logic [4:0]  reg_o, reg_n;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb               (bus),
    .rR1              (rR1),
    .rR2              (rR2),
    .rD1              (rD1),
    .rD2              (rD2),
    .dbg_wb_have_inst (have),
    .dbg_wb_pc        (pc),
    .dbg_wb_ena       (ena),
    .dbg_wb_reg       (reg_o),
    .dbg_wb_value     (value),
    .retire_cnt       (cnt)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk              (clk),
    .rst              (rst),
    .wb               (bus),
    .rR1              (rR2),
    .rR2              (rR1),
    .rD1              (rD1_n),
    .rD2              (rD2_n),
    .dbg_wb_have_inst (have_n),
    .dbg_wb_pc        (pc_n),
    .dbg_wb_ena       (ena_n),
    .dbg_wb_reg       (reg_n),
    .dbg_wb_value     (value_n),
    .retire_cnt       (cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural state as plain arrays and counters.
  logic [31:0] m_regs [32];
  logic        m_have, m_ena;
  logic [31:0] m_pc, m_value;
  logic [4:0]  m_reg;
  longint unsigned m_cnt;
  logic [31:0] s_rD1, s_rD2;

  typedef struct {
    logic        r;
    logic        f;
    logic [1:0]  we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_have;
    logic        e_ena;
    logic [31:0] e_pc;
    logic [4:0]  e_reg;
    logic [31:0] e_val;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] ra, input logic cm,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (cm && ra == wr) return wd;
    return m_regs[ra];
  endfunction

  // One clock cycle: drive, check reads mid-cycle, clock, update model, check registered outputs.
  task automatic step(input logic r, input logic f, input logic [1:0] we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [31:0] wpc,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic cm;
    rst = r;
    bus.wb_flag = f;
    bus.wb_rf_we = we;
    bus.wb_wR = wr;
    bus.wb_wD = wd;
    bus.wb_pc = wpc;
    rR1 = r1;
    rR2 = r2;
    cm = f && (we != 2'b00) && (wr != 5'd0);
    @(negedge clk);
    s_rD1 = rD1;
    s_rD2 = rD2;
    chk("rD1", rD1, m_read(r1, cm, wr, wd));
    chk("rD2", rD2, m_read(r2, cm, wr, wd));
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_have = 1'b0; m_ena = 1'b0; m_pc = 32'd0; m_reg = 5'd0; m_value = 32'd0; m_cnt = 0;
    end else begin
      if (cm) m_regs[wr] = wd;
      m_have = f;
      m_ena = cm;
      if (f) begin
        m_pc = wpc; m_reg = wr; m_value = wd; m_cnt++;
      end
    end
    chk("have_inst", {31'd0, have}, {31'd0, m_have});
    chk("ena", {31'd0, ena}, {31'd0, m_ena});
    chk("pc", pc, m_pc);
    chk("reg", {27'd0, reg_o}, {27'd0, m_reg});
    chk("value", value, m_value);
    chk("retire_cnt", cnt, m_cnt[31:0]);
    chk("retire_cnt4", {28'd0, cnt4}, {28'd0, m_cnt[3:0]});
  endtask

  initial begin
    logic [4:0] wr, r1, r2;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_have = 0; m_ena = 0; m_pc = 0; m_reg = 0; m_value = 0; m_cnt = 0;
    rst = 1'b1;
    bus.wb_flag = 0; bus.wb_rf_we = 0; bus.wb_wR = 0; bus.wb_wD = 0; bus.wb_pc = 0;
    rR1 = 0; rR2 = 0;

    // Directed vectors from a clean reset: r f we wr wd pc r1 r2 | rd1 rd2 have ena pc reg val cnt
    tab[0] = '{0, 1, 2'b01, 5'd5, 32'hDEADBEEF, 32'h100, 5'd0, 5'd5,
               32'h0, 32'hDEADBEEF, 1, 1, 32'h100, 5'd5, 32'hDEADBEEF, 32'd1};
    tab[1] = '{0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0,
               32'hDEADBEEF, 32'h0, 0, 0, 32'h100, 5'd5, 32'hDEADBEEF, 32'd1};
    tab[2] = '{0, 1, 2'b10, 5'd7, 32'h5555, 32'h104, 5'd7, 5'd7,
               32'h5555, 32'h5555, 1, 1, 32'h104, 5'd7, 32'h5555, 32'd2};
    tab[3] = '{0, 1, 2'b01, 5'd7, 32'h1234, 32'h108, 5'd5, 5'd7,
               32'hDEADBEEF, 32'h1234, 1, 1, 32'h108, 5'd7, 32'h1234, 32'd3};
    tab[4] = '{0, 1, 2'b01, 5'd3, 32'h33, 32'h110, 5'd3, 5'd0,
               32'h33, 32'h0, 1, 1, 32'h110, 5'd3, 32'h33, 32'd4};
    tab[5] = '{0, 1, 2'b11, 5'd0, 32'hFFFFFFFF, 32'h114, 5'd0, 5'd7,
               32'h0, 32'h1234, 1, 0, 32'h114, 5'd0, 32'hFFFFFFFF, 32'd5};
    tab[6] = '{0, 0, 2'b11, 5'd3, 32'hCAFEF00D, 32'h200, 5'd3, 5'd0,
               32'h33, 32'h0, 0, 0, 32'h114, 5'd0, 32'hFFFFFFFF, 32'd5};
    tab[7] = '{0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd7,
               32'h33, 32'h1234, 0, 0, 32'h114, 5'd0, 32'hFFFFFFFF, 32'd5};

    step(1, 0, 2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    step(1, 0, 2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);

    for (int i = 0; i < 8; i++) begin
      step(tab[i].r, tab[i].f, tab[i].we, tab[i].wr, tab[i].wd, tab[i].wpc, tab[i].r1, tab[i].r2);
      chk($sformatf("tab%0d_rD1", i), s_rD1, tab[i].e_rd1);
      chk($sformatf("tab%0d_rD2", i), s_rD2, tab[i].e_rd2);
      chk($sformatf("tab%0d_have", i), {31'd0, have}, {31'd0, tab[i].e_have});
      chk($sformatf("tab%0d_ena", i), {31'd0, ena}, {31'd0, tab[i].e_ena});
      chk($sformatf("tab%0d_pc", i), pc, tab[i].e_pc);
      chk($sformatf("tab%0d_reg", i), {27'd0, reg_o}, {27'd0, tab[i].e_reg});
      chk($sformatf("tab%0d_val", i), value, tab[i].e_val);
      chk($sformatf("tab%0d_cnt", i), cnt, tab[i].e_cnt);
    end

    // Reset colliding with a commit: bypass visible now, write lost, everything cleared after.
    step(1, 1, 2'b01, 5'd9, 32'hAA, 32'h300, 5'd9, 5'd3);
    chk("rst_bypass_rD1", s_rD1, 32'hAA);
    chk("rst_old_rD2", s_rD2, 32'h33);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_trace", {have, ena, reg_o, pc[7:0], value[7:0]}, 32'd0);
    step(0, 0, 2'b00, 5'd0, 32'd0, 32'd0, 5'd9, 5'd3);
    chk("rst_x9", s_rD1, 32'd0);
    chk("rst_x3", s_rD2, 32'd0);
    step(0, 0, 2'b00, 5'd0, 32'd0, 32'd0, 5'd5, 5'd7);
    chk("rst_x5", s_rD1, 32'd0);
    chk("rst_x7", s_rD2, 32'd0);

    // Counter wrap on the 4-bit instance: 16 retires from reset -> 0, 17th -> 1.
    step(1, 0, 2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 2'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom, 5'($urandom),
           5'($urandom));
    end
    chk("wrap16_cnt4", {28'd0, cnt4}, 32'd0);
    chk("wrap16_cnt", cnt, 32'd16);
    step(0, 1, 2'b01, 5'd1, 32'h1, 32'h0, 5'd1, 5'd0);
    chk("wrap17_cnt4", {28'd0, cnt4}, 32'd1);

    // Random traffic against the model; reads often aimed at the write target.
    for (int i = 0; i < 400; i++) begin
      wr = 5'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           wr, $urandom, $urandom, r1, r2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
